// File: rtl/multicycle_control.sv
// Multicycle main-control FSM: steps each instruction through fetch, decode,
// execute, memory and write-back, and drives every datapath control strobe.
module multicycle_control #(
  parameter int                 OPC_W   = 6,
  parameter int                 CNT_W   = 32,
  parameter logic [OPC_W-1:0]   OP_R    = OPC_W'(6'h00),
  parameter logic [OPC_W-1:0]   OP_LW   = OPC_W'(6'h23),
  parameter logic [OPC_W-1:0]   OP_SW   = OPC_W'(6'h2B),
  parameter logic [OPC_W-1:0]   OP_BEQ  = OPC_W'(6'h04),
  parameter logic [OPC_W-1:0]   OP_ADDI = OPC_W'(6'h08),
  parameter logic [OPC_W-1:0]   OP_J    = OPC_W'(6'h02)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             mem_ready,
  input  logic             halt,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Memory handshake: a read or write strobe is held steady until the cycle
  // mem_ready=1, which completes the access; the FSM advances on that edge.
  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 2'd0;
    pc_source     = 2'd0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          if (!halt) begin
            mem_read  = 1'b1;
            alu_src_b = 2'd1;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready) state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'd3;
          case (opcode)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_R:         state_d = S_EXEC;
            OP_BEQ:       state_d = S_BRANCH;
            OP_ADDI:      state_d = S_ADDIEX;
            OP_J:         state_d = S_JUMP;
            default: begin
              illegal_op = 1'b1;
              state_d    = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          if (opcode == OP_LW)      state_d = S_MEMRD;
          else if (opcode == OP_SW) state_d = S_MEMWR;
          else                      state_d = S_FETCH;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (mem_ready) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'd2;
          state_d   = S_ALUWB;
        end
        S_ALUWB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'd1;
          pc_write_cond = 1'b1;
          pc_source     = 2'd1;
          instr_done    = 1'b1;
          state_d       = S_FETCH;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          alu_op    = 2'd3;
          state_d   = S_ADDIWB;
        end
        S_ADDIWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = 2'd2;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign count_d = instr_done ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Registered values are masked while reset is held so nothing leaks out.
  assign state       = rst_n ? state_q : 4'd0;
  assign instr_count = rst_n ? count_q : '0;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state and strobe vectors
// for each instruction class, halt, illegal opcode, reset and counter wrap.
module tb_multicycle_control;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    opcode;
  logic          mem_ready;
  logic          halt;
  logic          pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic          mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]    alu_src_b, alu_op, pc_source;
  logic [3:0]    state;
  logic          instr_done, illegal_op;
  logic [CW-1:0] instr_count;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_cnt;

  localparam logic [5:0] LW = 6'h23, SW = 6'h2B, RF = 6'h00, BEQ = 6'h04,
                         ADDI = 6'h08, JMP = 6'h02, BAD = 6'h3F;

  // Control-vector bit masks, one per strobe/field value.
  localparam logic [17:0] PCW = 18'h1 << 17, PCWC = 18'h1 << 16, IORD = 18'h1 << 15,
    MRD = 18'h1 << 14, MWR = 18'h1 << 13, IRW = 18'h1 << 12, M2R = 18'h1 << 11,
    RDST = 18'h1 << 10, RW = 18'h1 << 9, SRCA = 18'h1 << 8,
    SB4 = 18'h1 << 6, SBIMM = 18'h2 << 6, SBSH = 18'h3 << 6,
    OSUB = 18'h1 << 4, OFN = 18'h2 << 4, OADDI = 18'h3 << 4,
    PCSOUT = 18'h1 << 2, PCSJ = 18'h2 << 2, DONE = 18'h1 << 1, ILL = 18'h1;
  localparam logic [17:0] FW = MRD | SB4;             // fetch, waiting
  localparam logic [17:0] FR = MRD | SB4 | IRW | PCW; // fetch, ready

  logic [17:0] ctrl;
  assign ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                 pc_source, instr_done, illegal_op};

  multicycle_control #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .halt(halt),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; halt = 1'b0; mem_ready = 1'b1; opcode = LW;
    tick; tick;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (ctrl !== 18'h0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", ctrl); end
    checks++; if (instr_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", instr_count); end
    rst_n = 1'b1; mem_ready = 1'b0;
    #1;
    checks++; if (ctrl !== FW) begin errors++; $display("FAIL reset_release_ctrl: got %h want %h", ctrl, FW); end
    exp_cnt = '0;
  endtask

  task automatic test_lw;
    int          st [0:8] = '{0, 0, 0, 1, 2, 3, 3, 4, 0};
    logic        mr [0:8] = '{0, 0, 1, 1, 1, 0, 1, 1, 0};
    logic [17:0] ex [0:8] = '{FW, FW, FR, SBSH, SRCA | SBIMM, MRD | IORD,
                              MRD | IORD, RW | M2R | DONE, FW};
    opcode = LW; halt = 1'b0;
    for (int i = 0; i < 9; i++) begin
      mem_ready = mr[i];
      #1;
      checks++; if (state !== 4'(st[i])) begin errors++; $display("FAIL lw_state c%0d: got %0d want %0d", i, state, st[i]); end
      checks++; if (ctrl !== ex[i]) begin errors++; $display("FAIL lw_ctrl c%0d: got %h want %h", i, ctrl, ex[i]); end
      tick;
    end
    exp_cnt = exp_cnt + 1'b1;
    checks++; if (instr_count !== exp_cnt) begin errors++; $display("FAIL lw_count: got %0d want %0d", instr_count, exp_cnt); end
  endtask

  task automatic test_r_addi_j;
    int          st [0:11] = '{0, 1, 6, 7, 0, 1, 9, 10, 0, 1, 11, 0};
    logic [5:0]  oc [0:11] = '{RF, RF, RF, RF, ADDI, ADDI, ADDI, ADDI, JMP, JMP, JMP, JMP};
    logic [17:0] ex [0:11] = '{FR, SBSH, SRCA | OFN, RDST | RW | DONE,
                               FR, SBSH, SRCA | SBIMM | OADDI, RW | DONE,
                               FR, SBSH, PCW | PCSJ | DONE, FW};
    halt = 1'b0;
    for (int i = 0; i < 12; i++) begin
      opcode = oc[i]; mem_ready = (i != 11);
      #1;
      checks++; if (state !== 4'(st[i])) begin errors++; $display("FAIL rij_state c%0d: got %0d want %0d", i, state, st[i]); end
      checks++; if (ctrl !== ex[i]) begin errors++; $display("FAIL rij_ctrl c%0d: got %h want %h", i, ctrl, ex[i]); end
      tick;
    end
    exp_cnt = exp_cnt + 4'd3;
    checks++; if (instr_count !== exp_cnt) begin errors++; $display("FAIL rij_count: got %0d want %0d", instr_count, exp_cnt); end
  endtask

  task automatic test_beq_sw;
    int          st [0:9] = '{0, 1, 8, 0, 1, 2, 5, 5, 5, 0};
    logic        mr [0:9] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 0};
    logic [5:0]  oc [0:9] = '{BEQ, BEQ, BEQ, SW, SW, SW, SW, SW, SW, SW};
    logic [17:0] ex [0:9] = '{FR, SBSH, SRCA | OSUB | PCWC | PCSOUT | DONE,
                              FR, SBSH, SRCA | SBIMM, MWR | IORD, MWR | IORD,
                              MWR | IORD | DONE, FW};
    halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      opcode = oc[i]; mem_ready = mr[i];
      #1;
      checks++; if (state !== 4'(st[i])) begin errors++; $display("FAIL bsw_state c%0d: got %0d want %0d", i, state, st[i]); end
      checks++; if (ctrl !== ex[i]) begin errors++; $display("FAIL bsw_ctrl c%0d: got %h want %h", i, ctrl, ex[i]); end
      tick;
    end
    exp_cnt = exp_cnt + 4'd2;
    checks++; if (instr_count !== exp_cnt) begin errors++; $display("FAIL bsw_count: got %0d want %0d", instr_count, exp_cnt); end
  endtask

  task automatic test_illegal;
    int          st [0:2] = '{0, 1, 0};
    logic        mr [0:2] = '{1, 1, 0};
    logic [17:0] ex [0:2] = '{FR, SBSH | ILL, FW};
    opcode = BAD; halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_ready = mr[i];
      #1;
      checks++; if (state !== 4'(st[i])) begin errors++; $display("FAIL ill_state c%0d: got %0d want %0d", i, state, st[i]); end
      checks++; if (ctrl !== ex[i]) begin errors++; $display("FAIL ill_ctrl c%0d: got %h want %h", i, ctrl, ex[i]); end
      tick;
    end
    checks++; if (instr_count !== exp_cnt) begin errors++; $display("FAIL ill_count: got %0d want %0d", instr_count, exp_cnt); end
  endtask

  task automatic test_halt;
    int          st [0:9] = '{0, 0, 0, 0, 0, 0, 1, 6, 7, 0};
    logic        hl [0:9] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1};
    logic [17:0] ex [0:9] = '{18'h0, 18'h0, 18'h0, 18'h0, 18'h0, FR, SBSH,
                              SRCA | OFN, RDST | RW | DONE, 18'h0};
    rst_n = 1'b0; halt = 1'b1; mem_ready = 1'b1; opcode = RF;
    tick;
    rst_n = 1'b1;
    exp_cnt = '0;
    for (int i = 0; i < 10; i++) begin
      halt = hl[i];
      #1;
      checks++; if (state !== 4'(st[i])) begin errors++; $display("FAIL halt_state c%0d: got %0d want %0d", i, state, st[i]); end
      checks++; if (ctrl !== ex[i]) begin errors++; $display("FAIL halt_ctrl c%0d: got %h want %h", i, ctrl, ex[i]); end
      tick;
    end
    halt = 1'b0; mem_ready = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    checks++; if (instr_count !== exp_cnt) begin errors++; $display("FAIL halt_count: got %0d want %0d", instr_count, exp_cnt); end
  endtask

  task automatic test_reset_mid;
    int          st [0:3] = '{0, 1, 2, 3};
    logic [17:0] ex [0:3] = '{FR, SBSH, SRCA | SBIMM, MRD | IORD};
    opcode = LW; halt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i != 3);
      #1;
      checks++; if (state !== 4'(st[i])) begin errors++; $display("FAIL rmid_state c%0d: got %0d want %0d", i, state, st[i]); end
      checks++; if (ctrl !== ex[i]) begin errors++; $display("FAIL rmid_ctrl c%0d: got %h want %h", i, ctrl, ex[i]); end
      if (i != 3) tick;
    end
    rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    checks++; if (ctrl !== 18'h0) begin errors++; $display("FAIL rmid_held_ctrl: got %h want 0", ctrl); end
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL rmid_held_state: got %0d want 0", state); end
    tick;
    rst_n = 1'b1; mem_ready = 1'b0;
    #1;
    exp_cnt = '0;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL rmid_after_state: got %0d want 0", state); end
    checks++; if (ctrl !== FW) begin errors++; $display("FAIL rmid_after_ctrl: got %h want %h", ctrl, FW); end
    checks++; if (instr_count !== exp_cnt) begin errors++; $display("FAIL rmid_count: got %0d want 0", instr_count); end
    tick;
  endtask

  task automatic test_wrap;
    opcode = JMP; halt = 1'b0; mem_ready = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick; tick; tick;
      exp_cnt = exp_cnt + 1'b1;
      if (n == 15 || n == 16) begin
        checks++; if (instr_count !== exp_cnt) begin errors++; $display("FAIL wrap_count n%0d: got %0d want %0d", n, instr_count, exp_cnt); end
      end
    end
    mem_ready = 1'b0;
    #1;
    checks++; if (instr_count !== 4'd0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", instr_count); end
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL wrap_state: got %0d want 0", state); end
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; mem_ready = 1'b0; halt = 1'b0; exp_cnt = '0;
    #1;
    test_reset;
    test_lw;
    test_r_addi_j;
    test_beq_sw;
    test_illegal;
    test_halt;
    test_reset_mid;
    test_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
